// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the frame-buffer subsystem.
// Holds the arbiter state encoding, the requester IDs and the frame and
// burst geometry defaults. The camera capture and HDMI fetch blocks use
// the same geometry constants so that all of them agree on the frame layout.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST
    } fb_state_t;

    typedef enum logic [1:0] {
        RID_RD,
        RID_WR0,
        RID_WR1
    } fb_rid_t;

    localparam int FB_ADDR_W      = 21;
    localparam int FB_DATA_W      = 8;
    localparam int FB_BURST_LEN   = 16;
    localparam int FB_RD_LAT      = 2;
    localparam int FB_FRAME_WORDS = 307200;

endpackage

// File: rtl/fb_rd_valid_pipe.sv
// fb_rd_valid_pipe: read-return delay line for the frame-buffer arbiter.
// An accepted read beat enters as in_valid. out_valid rises DEPTH clock edges
// later. out_data is loaded from in_data on that same edge, so the memory must
// present the beat's data DEPTH-1 cycles after the beat was issued.
// Ports:
//   clk_low   pixel clock
//   reset_n   asynchronous active-low clear of flags and data
//   in_valid  read beat accepted this cycle
//   in_data   memory read data bus
//   out_valid registered read-data strobe
//   out_data  registered read data
module fb_rd_valid_pipe #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk_low,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0] flags;
    logic             capture;

    // Data is captured on the edge where a flag moves into the last stage.
    generate
        if (DEPTH == 1) begin : g_single
            assign capture = in_valid;
        end else begin : g_multi
            assign capture = flags[DEPTH-2];
        end
    endgenerate

    assign out_valid = flags[DEPTH-1];

    // Flag shift register plus output data register.
    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n) begin
            flags    <= '0;
            out_data <= '0;
        end else begin
            flags <= (flags << 1) | DEPTH'(in_valid);
            if (capture) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares one single-port frame-buffer memory between the HDMI
// scan-out reader and two camera writers, in fixed-length bursts.
// Reads have priority, but after a read burst a waiting writer is always
// served next. Writers are served round-robin between themselves.
// Ports:
//   clk_low, reset_n              pixel clock, async active-low reset
//   rd_req/rd_addr/rd_gnt         HDMI burst request, start address, grant pulse
//   rd_data/rd_valid              returned read data and strobe
//   wrN_req/wrN_addr/wrN_data     camera burst request, start address, beat data
//   wrN_gnt/wrN_beat              grant pulse, beat consumed this cycle
//   mem_en/mem_we/mem_addr        memory beat strobe, direction, address
//   mem_wdata/mem_rdata/mem_ready memory data in/out, beat acceptance
//   busy                          burst in progress
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int DATA_W      = FB_DATA_W,
    parameter int BURST_LEN   = FB_BURST_LEN,
    parameter int RD_LAT      = FB_RD_LAT,
    parameter int FRAME_WORDS = FB_FRAME_WORDS
) (
    input  logic              clk_low,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr0_req,
    input  logic              wr1_req,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr0_gnt,
    output logic              wr1_gnt,
    output logic              wr0_beat,
    output logic              wr1_beat,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int                CNT_W     = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

    fb_state_t         state;
    fb_rid_t           sel;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  beat_cnt;
    logic              last_was_read;
    logic              rr_wr1;
    logic              any_wr;
    logic              pick_rd;
    logic              pick_wr1;
    logic              accept;

    // A read yields to a waiting writer only directly after a read burst.
    // rr_wr1 names the writer preferred when both ask (0 = wr0, 1 = wr1).
    assign any_wr   = wr0_req | wr1_req;
    assign pick_rd  = rd_req && !(last_was_read && any_wr);
    assign pick_wr1 = wr1_req && (!wr0_req || rr_wr1);

    // Beats follow mem_ready directly so a stall costs no extra cycle.
    assign accept    = (state != IDLE) && mem_ready;
    assign mem_en    = accept;
    assign mem_we    = (state == WR_BURST);
    assign mem_addr  = addr;
    assign busy      = (state != IDLE);
    assign wr0_beat  = accept && (state == WR_BURST) && (sel == RID_WR0);
    assign wr1_beat  = accept && (state == WR_BURST) && (sel == RID_WR1);
    assign mem_wdata = (sel == RID_WR1) ? wr1_data : wr0_data;

    // Arbitration and burst sequencing. Grants are registered pulses that
    // coincide with the first burst cycle, so beat 0 can issue alongside them.
    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sel           <= RID_RD;
            addr          <= '0;
            beat_cnt      <= '0;
            last_was_read <= 1'b0;
            rr_wr1        <= 1'b0;
            rd_gnt        <= 1'b0;
            wr0_gnt       <= 1'b0;
            wr1_gnt       <= 1'b0;
        end else begin
            rd_gnt  <= 1'b0;
            wr0_gnt <= 1'b0;
            wr1_gnt <= 1'b0;
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (pick_rd) begin
                        state  <= RD_BURST;
                        sel    <= RID_RD;
                        addr   <= rd_addr;
                        rd_gnt <= 1'b1;
                    end else if (any_wr) begin
                        state <= WR_BURST;
                        if (pick_wr1) begin
                            sel     <= RID_WR1;
                            addr    <= wr1_addr;
                            wr1_gnt <= 1'b1;
                        end else begin
                            sel     <= RID_WR0;
                            addr    <= wr0_addr;
                            wr0_gnt <= 1'b1;
                        end
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (mem_ready) begin
                        addr     <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state         <= IDLE;
                            last_was_read <= (state == RD_BURST);
                            if (state == WR_BURST) begin
                                rr_wr1 <= (sel == RID_WR0);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read return path keeps draining independently of the burst state.
    fb_rd_valid_pipe #(
        .DEPTH  (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk_low   (clk_low),
        .reset_n   (reset_n),
        .in_valid  (accept && (state == RD_BURST)),
        .in_data   (mem_rdata),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

`ifndef SYNTHESIS
    // Start addresses beyond the frame are meaningless; catch them in simulation.
    always @(posedge clk_low) begin
        if (reset_n && state == IDLE) begin
            if (pick_rd) begin
                assert (rd_addr <= LAST_ADDR);
            end else if (any_wr && pick_wr1) begin
                assert (wr1_addr <= LAST_ADDR);
            end else if (any_wr) begin
                assert (wr0_addr <= LAST_ADDR);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter: self-checking bench for fb_mem_arbiter.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. The memory is modelled as a synchronous RAM whose read data
// appears on mem_rdata the cycle after the read beat.
module tb_fb_mem_arbiter;

    localparam int ADDR_W      = 21;
    localparam int DATA_W      = 8;
    localparam int FRAME_WORDS = 307200;

    logic              clk_low;
    logic              reset_n;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr0_req, wr1_req;
    logic [ADDR_W-1:0] wr0_addr, wr1_addr;
    logic [DATA_W-1:0] wr0_data, wr1_data;
    logic              wr0_gnt, wr1_gnt;
    logic              wr0_beat, wr1_beat;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       rd;
        logic       wr0;
        logic       wr1;
        logic [2:0] exp_gnt;
        logic [4:0] exp_beats;
    } arb_vec_t;

    arb_vec_t vecs [14];

    fb_mem_arbiter dut (
        .clk_low   (clk_low),
        .reset_n   (reset_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr0_req   (wr0_req),
        .wr1_req   (wr1_req),
        .wr0_addr  (wr0_addr),
        .wr1_addr  (wr1_addr),
        .wr0_data  (wr0_data),
        .wr1_data  (wr1_data),
        .wr0_gnt   (wr0_gnt),
        .wr1_gnt   (wr1_gnt),
        .wr0_beat  (wr0_beat),
        .wr1_beat  (wr1_beat),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    initial clk_low = 1'b0;
    always #5 clk_low = ~clk_low;

    function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // Synchronous RAM read model, zero on cycles without a read beat.
    always @(posedge clk_low) begin
        if (mem_en && !mem_we) mem_rdata <= mem_val(mem_addr);
        else                   mem_rdata <= 8'h00;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        rd_req = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk_low);
        #1 reset_n = 1'b1;
    endtask

    // Raise the given requests from IDLE, wait for a grant, drop the requests
    // and count accepted beats until busy falls.
    task automatic applyStimulus(input logic rq, input logic w0, input logic w1,
                                 input logic [ADDR_W-1:0] start,
                                 output logic [2:0] gnt, output logic [2:0] gnt_next,
                                 output int beats);
        int gnt_wait;
        rd_req = rq; wr0_req = w0; wr1_req = w1;
        rd_addr = start; wr0_addr = start; wr1_addr = start;
        gnt = '0; gnt_next = '0; beats = 0; gnt_wait = 0;
        while (gnt == 3'b000 && gnt_wait < 20) begin
            @(negedge clk_low);
            gnt = {rd_gnt, wr0_gnt, wr1_gnt};
            gnt_wait++;
        end
        if (gnt != 3'b000) beats += int'(mem_en);
        @(posedge clk_low); #1;
        rd_req = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
        if (gnt != 3'b000) begin
            for (int i = 0; i < 100; i++) begin
                @(negedge clk_low);
                if (i == 0) gnt_next = {rd_gnt, wr0_gnt, wr1_gnt};
                if (!busy) break;
                beats += int'(mem_en);
            end
            @(posedge clk_low); #1;
        end
    endtask

    logic [2:0]        g, g2;
    int                beats, vcnt, first_valid, last_beat, busy_cycles;
    int                addr_err, we_err, data_err, stall_err, extra_gnt, idle_err;
    logic              found, busy_at;
    logic [ADDR_W-1:0] exp_addr, last_addr;
    logic              pat [4];

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 3'b100, 5'd16};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 3'b010, 5'd16};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 3'b100, 5'd16};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 3'b001, 5'd16};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 3'b100, 5'd16};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 3'b010, 5'd16};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'b100, 5'd16};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'b100, 5'd16};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 3'b001, 5'd16};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 3'b010, 5'd16};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 3'b001, 5'd16};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 3'b100, 5'd16};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 3'b010, 5'd16};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 3'b000, 5'd0};
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        rd_addr = '0; wr0_addr = '0; wr1_addr = '0;
        wr0_data = 8'h00; wr1_data = 8'hEE;

        // Reset state, sampled while reset is held.
        reset_n = 1'b0;
        rd_req = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk_low);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_mem_en", mem_en, 0);
        checkOutput("reset_mem_addr", mem_addr, 0);
        checkOutput("reset_gnts", {rd_gnt, wr0_gnt, wr1_gnt, wr0_beat, wr1_beat}, 0);
        checkOutput("reset_rd", {rd_valid, rd_data}, 0);
        @(posedge clk_low); #1 reset_n = 1'b1;

        // Single read burst from address 100.
        $display("[TB] single read burst");
        rd_addr = 21'd100; rd_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk_low);
            if (rd_gnt) found = 1'b1;
        end
        checkOutput("single_rd_gnt", found, 1);
        rd_req = 1'b0;
        beats = 0; vcnt = 0; first_valid = -1; last_beat = -1;
        addr_err = 0; we_err = 0; data_err = 0; busy_at = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if (n > 0) @(negedge clk_low);
            if (mem_en) begin
                if (mem_addr != ADDR_W'(100 + beats)) addr_err++;
                if (mem_we) we_err++;
                last_beat = n;
                beats++;
            end
            if (rd_valid) begin
                if (first_valid < 0) first_valid = n;
                if (rd_data != mem_val(ADDR_W'(100 + vcnt))) data_err++;
                vcnt++;
            end
            if (n == 16) busy_at = busy;
        end
        checkOutput("single_rd_beats", beats, 16);
        checkOutput("single_rd_last_beat_cycle", last_beat, 15);
        checkOutput("single_rd_addr_errors", addr_err, 0);
        checkOutput("single_rd_we_errors", we_err, 0);
        checkOutput("single_rd_valid_count", vcnt, 16);
        checkOutput("single_rd_first_valid_cycle", first_valid, 2);
        checkOutput("single_rd_data_errors", data_err, 0);
        checkOutput("single_rd_busy_after", busy_at, 0);

        // Arbitration table.
        $display("[TB] arbitration table");
        doReset();
        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].rd, vecs[v].wr0, vecs[v].wr1, ADDR_W'(1000 + v * 32), g, g2, beats);
            checkOutput($sformatf("arb%0d_gnt", v), g, vecs[v].exp_gnt);
            checkOutput($sformatf("arb%0d_beats", v), beats, vecs[v].exp_beats);
            if (vecs[v].exp_gnt != 3'b000) checkOutput($sformatf("arb%0d_gnt_pulse", v), g2, 0);
        end

        // Write burst wrapping at the frame end.
        $display("[TB] wrap write burst");
        wr0_addr = ADDR_W'(FRAME_WORDS - 5); wr0_data = 8'h10; wr0_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk_low);
            if (wr0_gnt) found = 1'b1;
        end
        checkOutput("wrap_gnt", found, 1);
        exp_addr = ADDR_W'(FRAME_WORDS - 5);
        beats = 0; addr_err = 0; data_err = 0; we_err = 0; last_addr = '0;
        for (int n = 0; n < 25; n++) begin
            if (n > 0) @(negedge clk_low);
            if (wr1_beat) we_err++;
            if (wr0_beat) begin
                if (mem_addr != exp_addr) addr_err++;
                if (mem_wdata != wr0_data) data_err++;
                if (!mem_we || !mem_en) we_err++;
                last_addr = mem_addr;
                exp_addr = (exp_addr == ADDR_W'(FRAME_WORDS - 1)) ? '0 : exp_addr + 1'b1;
                beats++;
            end
            found = wr0_beat;
            @(posedge clk_low); #1;
            if (found) wr0_data = wr0_data + 8'd1;
            if (n == 0) wr0_req = 1'b0;
        end
        checkOutput("wrap_beats", beats, 16);
        checkOutput("wrap_addr_errors", addr_err, 0);
        checkOutput("wrap_wdata_errors", data_err, 0);
        checkOutput("wrap_we_errors", we_err, 0);
        checkOutput("wrap_last_addr", last_addr, 10);

        // Write burst with mem_ready stalls.
        $display("[TB] stalled write burst");
        wr0_addr = 21'd500; wr0_req = 1'b1; mem_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk_low);
            if (wr0_gnt) found = 1'b1;
        end
        checkOutput("stall_gnt", found, 1);
        exp_addr = 21'd500; beats = 0; addr_err = 0; stall_err = 0; busy_cycles = 0;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk_low);
            if (busy) begin
                busy_cycles++;
                if (mem_addr != exp_addr) addr_err++;
                if (wr0_beat != mem_ready || mem_en != mem_ready || wr1_beat) stall_err++;
                if (wr0_beat) begin
                    beats++;
                    exp_addr = exp_addr + 1'b1;
                end
            end
            @(posedge clk_low); #1;
            mem_ready = pat[(n + 1) % 4];
            if (n == 0) wr0_req = 1'b0;
        end
        mem_ready = 1'b1;
        checkOutput("stall_beats", beats, 16);
        checkOutput("stall_addr_errors", addr_err, 0);
        checkOutput("stall_beat_errors", stall_err, 0);
        checkOutput("stall_busy_cycles", busy_cycles, 32);

        // Writer request that disappears before it could be arbitrated.
        $display("[TB] early request drop");
        rd_addr = 21'd2000; rd_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk_low);
            if (rd_gnt) found = 1'b1;
        end
        checkOutput("drop_rd_gnt", found, 1);
        extra_gnt = 0; idle_err = 0;
        for (int n = 1; n < 40; n++) begin
            @(posedge clk_low); #1;
            if (n == 1) rd_req = 1'b0;
            if (n == 3) wr1_req = 1'b1;
            if (n == 4) wr1_req = 1'b0;
            @(negedge clk_low);
            if (rd_gnt || wr0_gnt || wr1_gnt) extra_gnt++;
            if (n >= 20 && (busy || mem_en)) idle_err++;
        end
        checkOutput("drop_extra_grants", extra_gnt, 0);
        checkOutput("drop_idle_activity", idle_err, 0);

        // Reset in the middle of a read burst.
        $display("[TB] reset mid-read");
        @(posedge clk_low); #1;
        rd_addr = 21'd3000; rd_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk_low);
            if (rd_gnt) found = 1'b1;
        end
        checkOutput("rstmid_gnt", found, 1);
        rd_req = 1'b0;
        repeat (5) @(negedge clk_low);
        checkOutput("rstmid_beat5_addr", mem_addr, 3005);
        reset_n = 1'b0;
        #1;
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_mem_en", mem_en, 0);
        checkOutput("rstmid_mem_addr", mem_addr, 0);
        checkOutput("rstmid_rd", {rd_valid, rd_data}, 0);
        repeat (2) @(posedge clk_low);
        #1 reset_n = 1'b1;
        vcnt = 0; idle_err = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk_low);
            if (rd_valid) vcnt++;
            if (busy || mem_en) idle_err++;
        end
        checkOutput("rstmid_no_valid", vcnt, 0);
        checkOutput("rstmid_idle", idle_err, 0);
        @(posedge clk_low); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 21'd4000, g, g2, beats);
        checkOutput("rstmid_rd_vs_wr1_gnt", g, 3'b100);
        applyStimulus(1'b0, 1'b0, 1'b1, 21'd4100, g, g2, beats);
        checkOutput("rstmid_wr1_gnt", g, 3'b001);
        checkOutput("rstmid_wr1_beats", beats, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
